// File: rtl/wb_uart_fifo.sv
// Wishbone UART: 8N1 TX/RX engines, power-of-two byte FIFOs, runtime divisor, level interrupts.
// Optional parity bit (CTRL[3] enable, CTRL[4] odd, STAT[8] parity_err) when WB_UART_PARITY_EN is defined.

module wb_uart_fifo_q #(parameter int DL2 = 4) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [7:0]   i_data,
  input  logic         i_pop,
  output logic [7:0]   o_data,
  output logic [DL2:0] o_count,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_push_ok
);
  logic [7:0]     r_mem [1<<DL2];
  logic [DL2-1:0] r_wp, r_rp;
  logic [DL2:0]   r_cnt;
  logic           w_pop_ok;

  assign o_count   = r_cnt;
  assign o_empty   = (r_cnt == '0);
  assign o_full    = r_cnt[DL2];
  // an empty queue hands a same-cycle push straight through to the popper
  assign w_pop_ok  = i_pop & (~o_empty | i_push);
  assign o_push_ok = i_push & (~o_full | i_pop);
  assign o_data    = o_empty ? (i_push ? i_data : 8'h00) : r_mem[r_rp];

  always_ff @(posedge clk)
    if (o_push_ok) r_mem[r_wp] <= i_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0; r_rp <= '0; r_cnt <= '0;
    end else begin
      if (o_push_ok) r_wp <= r_wp + DL2'(1);
      if (w_pop_ok)  r_rp <= r_rp + DL2'(1);
      case ({o_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + (DL2+1)'(1);
        2'b01:   r_cnt <= r_cnt - (DL2+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module wb_uart_fifo #(
  parameter int clk_freq      = 100000000,
  parameter int baud          = 115200,
  parameter int rx_depth_log2 = 4,
  parameter int tx_depth_log2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam logic [15:0] DIV_RST = 16'(clk_freq / baud - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic        r_ack, r_ovr, r_ferr, r_perr;
  logic [31:0] r_dat;
  logic [4:0]  r_ctrl;
  logic [15:0] r_div;
  logic [15:0] w_div_eff;
  logic        w_par_en, w_odd, w_acc, w_wr, w_rd, w_stat_wr;
  logic        w_ovr_set, w_ferr_set, w_perr_set, w_unused;
  logic [4:0]  w_ctrl_mask;
  logic [2:0]  w_adr;
  logic [31:0] w_rd_data, w_stat;

  logic                   w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_push_ok;
  logic [7:0]             w_tx_rdata;
  logic [tx_depth_log2:0] w_tx_count;
  logic                   w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_push_ok;
  logic [7:0]             w_rx_rdata;
  logic [rx_depth_log2:0] w_rx_count;

  state_t      r_tx_st, w_tx_st_n, r_rx_st, w_rx_st_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n, r_rx_cnt, w_rx_cnt_n;
  logic [7:0]  r_tx_sh, w_tx_sh_n, r_rx_sh, w_rx_sh_n;
  logic [2:0]  r_tx_bit, w_tx_bit_n, r_rx_bit, w_rx_bit_n;
  logic        r_tx_par, w_tx_par_n, r_txd, w_txd_n, w_tx_load;
  logic        r_rx_perr, w_rx_perr_n, r_rx_s1, r_rx_s2, r_rx_prev;

`ifdef WB_UART_PARITY_EN
  assign w_par_en    = r_ctrl[3];
  assign w_odd       = r_ctrl[4];
  assign w_ctrl_mask = 5'h1f;
`else
  assign w_par_en    = 1'b0;
  assign w_odd       = 1'b0;
  assign w_ctrl_mask = 5'h07;
`endif

  assign w_unused  = &{1'b0, wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16], w_tx_push_ok};
  assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;
  assign w_adr     = wb_adr_i[4:2];
  assign w_acc     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd      = w_acc & ~wb_we_i;
  assign w_stat_wr = w_wr & (w_adr == 3'd0);
  assign w_tx_push = w_wr & (w_adr == 3'd1);
  assign w_rx_pop  = w_rd & (w_adr == 3'd1);
  assign w_ovr_set = w_rx_push & ~w_rx_push_ok;
  assign wb_ack_o  = wb_stb_i & wb_cyc_i & r_ack;
  assign wb_dat_o  = r_dat;
  assign uart_txd  = r_txd;
  assign intr      = (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty) |
                     (r_ctrl[2] & (r_ovr | r_ferr | r_perr));

  wb_uart_fifo_q #(.DL2(tx_depth_log2)) u_txq (
    .clk(clk), .reset(reset), .i_push(w_tx_push), .i_data(wb_dat_i[7:0]), .i_pop(w_tx_pop),
    .o_data(w_tx_rdata), .o_count(w_tx_count), .o_full(w_tx_full), .o_empty(w_tx_empty),
    .o_push_ok(w_tx_push_ok));

  wb_uart_fifo_q #(.DL2(rx_depth_log2)) u_rxq (
    .clk(clk), .reset(reset), .i_push(w_rx_push), .i_data(r_rx_sh), .i_pop(w_rx_pop),
    .o_data(w_rx_rdata), .o_count(w_rx_count), .o_full(w_rx_full), .o_empty(w_rx_empty),
    .o_push_ok(w_rx_push_ok));

  assign w_stat = {23'd0,
`ifdef WB_UART_PARITY_EN
                   r_perr,
`else
                   1'b0,
`endif
                   intr, r_ferr, w_tx_empty & (r_tx_st == S_IDLE), w_tx_empty, w_tx_full,
                   r_ovr, w_rx_full, ~w_rx_empty};

  always_comb begin
    w_rd_data = '0;
    case (w_adr)
      3'd0:    w_rd_data = w_stat;
      3'd1:    w_rd_data = {24'd0, w_rx_rdata};
      3'd2:    w_rd_data = {27'd0, r_ctrl};
      3'd3:    w_rd_data = {16'd0, r_div};
      3'd4:    w_rd_data = {16'd0, 8'(w_tx_count), 8'(w_rx_count)};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0; r_dat <= '0; r_ctrl <= '0; r_div <= DIV_RST;
      r_ovr <= 1'b0; r_ferr <= 1'b0; r_perr <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_dat <= w_rd_data;
      if (w_wr && w_adr == 3'd2) r_ctrl <= wb_dat_i[4:0] & w_ctrl_mask;
      if (w_wr && w_adr == 3'd3) r_div <= wb_dat_i[15:0];
      r_ovr  <= (r_ovr  & ~(w_stat_wr & wb_dat_i[2])) | w_ovr_set;
      r_ferr <= (r_ferr & ~(w_stat_wr & wb_dat_i[6])) | w_ferr_set;
      r_perr <= (r_perr & ~(w_stat_wr & wb_dat_i[8])) | w_perr_set;
    end
  end

  // TX: each bit reloads the divisor, so a DIV write lands on the next bit boundary
  always_comb begin
    w_tx_st_n = r_tx_st; w_tx_cnt_n = r_tx_cnt; w_tx_sh_n = r_tx_sh; w_tx_bit_n = r_tx_bit;
    w_tx_par_n = r_tx_par; w_tx_pop = 1'b0; w_tx_load = 1'b0;
    if (r_tx_st != S_IDLE && r_tx_cnt != 16'd0) w_tx_cnt_n = r_tx_cnt - 16'd1;
    else begin
      w_tx_cnt_n = w_div_eff;
      case (r_tx_st)
        S_IDLE, S_STOP: begin
          w_tx_load = ~w_tx_empty;
          w_tx_st_n = w_tx_empty ? S_IDLE : S_START;
        end
        S_START: w_tx_st_n = S_DATA;
        S_DATA: if (r_tx_bit == 3'd7) w_tx_st_n = w_par_en ? S_PAR : S_STOP;
                else begin w_tx_bit_n = r_tx_bit + 3'd1; w_tx_sh_n = {1'b0, r_tx_sh[7:1]}; end
        S_PAR:   w_tx_st_n = S_STOP;
        default: w_tx_st_n = S_IDLE;
      endcase
      if (w_tx_load) begin
        w_tx_pop = 1'b1; w_tx_sh_n = w_tx_rdata; w_tx_bit_n = 3'd0;
        w_tx_par_n = ^w_tx_rdata ^ w_odd;
      end
    end
    case (w_tx_st_n)
      S_START: w_txd_n = 1'b0;
      S_DATA:  w_txd_n = w_tx_sh_n[0];
      S_PAR:   w_txd_n = w_tx_par_n;
      default: w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_st <= S_IDLE; r_tx_cnt <= '0; r_tx_sh <= '0; r_tx_bit <= '0;
      r_tx_par <= 1'b0; r_txd <= 1'b1;
    end else begin
      r_tx_st <= w_tx_st_n; r_tx_cnt <= w_tx_cnt_n; r_tx_sh <= w_tx_sh_n;
      r_tx_bit <= w_tx_bit_n; r_tx_par <= w_tx_par_n; r_txd <= w_txd_n;
    end
  end

  // RX: half-bit delay after the falling edge puts every later sample at mid-bit
  always_comb begin
    w_rx_st_n = r_rx_st; w_rx_cnt_n = r_rx_cnt; w_rx_sh_n = r_rx_sh; w_rx_bit_n = r_rx_bit;
    w_rx_perr_n = r_rx_perr; w_rx_push = 1'b0; w_ferr_set = 1'b0; w_perr_set = 1'b0;
    if (r_rx_st == S_IDLE) begin
      if (r_rx_prev && !r_rx_s2) begin
        w_rx_st_n = S_START; w_rx_cnt_n = {1'b0, w_div_eff[15:1]}; w_rx_perr_n = 1'b0;
      end
    end else if (r_rx_cnt != 16'd0) w_rx_cnt_n = r_rx_cnt - 16'd1;
    else begin
      w_rx_cnt_n = w_div_eff;
      case (r_rx_st)
        S_START: begin w_rx_bit_n = 3'd0; w_rx_st_n = r_rx_s2 ? S_IDLE : S_DATA; end
        S_DATA: begin
          w_rx_sh_n = {r_rx_s2, r_rx_sh[7:1]}; w_rx_bit_n = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_st_n = w_par_en ? S_PAR : S_STOP;
        end
        S_PAR: begin w_rx_perr_n = r_rx_s2 != (^r_rx_sh ^ w_odd); w_rx_st_n = S_STOP; end
        S_STOP: begin
          w_rx_st_n = S_IDLE;
          if (!r_rx_s2)      w_ferr_set = 1'b1;
          else if (r_rx_perr) w_perr_set = 1'b1;
          else                w_rx_push = 1'b1;
        end
        default: w_rx_st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_st <= S_IDLE; r_rx_cnt <= '0; r_rx_sh <= '0; r_rx_bit <= '0; r_rx_perr <= 1'b0;
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
    end else begin
      r_rx_st <= w_rx_st_n; r_rx_cnt <= w_rx_cnt_n; r_rx_sh <= w_rx_sh_n;
      r_rx_bit <= w_rx_bit_n; r_rx_perr <= w_rx_perr_n;
      r_rx_s1 <= uart_rxd; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
    end
  end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed bench for wb_uart_fifo: registers, TX framing, RX FIFO/overrun, errors, concurrency, reset.
module tb_wb_uart_fifo;
  logic        clk = 1'b0, reset = 1'b1;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, intr, uart_txd;
  logic        uart_rxd = 1'b1;
  int          n_cmp = 0, n_bad = 0;

  localparam logic [31:0] A_STAT = 32'h00, A_DATA = 32'h04, A_CTRL = 32'h08,
                          A_DIV = 32'h0C, A_LVL = 32'h10;

  always #5 clk = ~clk;

  wb_uart_fifo dut (
    .clk(clk), .reset(reset), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .intr(intr), .uart_rxd(uart_rxd), .uart_txd(uart_txd));

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     output logic [31:0] rdat);
    bit got = 1'b0;
    rdat = '0;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin got = 1'b1; rdat = wb_dat_o; end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin n_cmp++; n_bad++; $display("FAIL ack_timeout adr=%h", adr); end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] x;
    bus(1'b1, adr, dat, x);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
    bus(1'b0, adr, 32'd0, dat);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stopv, input int per);
    uart_rxd = 1'b0; repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; repeat (per) @(negedge clk); end
    uart_rxd = stopv; repeat (per) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b1; repeat (3) @(negedge clk); reset = 1'b0;
    n_cmp++; if (wb_dat_o !== 32'd0 || wb_ack_o !== 1'b0) begin n_bad++;
      $display("FAIL rst_bus dat=%h ack=%b want 0/0", wb_dat_o, wb_ack_o); end
    n_cmp++; if (uart_txd !== 1'b1 || intr !== 1'b0) begin n_bad++;
      $display("FAIL rst_pins txd=%b intr=%b want 1/0", uart_txd, intr); end
    rd(A_DIV, r);
    n_cmp++; if (r !== 32'd867) begin n_bad++; $display("FAIL rst_div got %0d want 867", r); end
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h30) begin n_bad++; $display("FAIL rst_stat got %h want 30", r); end
    rd(A_CTRL, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl got %h want 0", r); end
    rd(A_LVL, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rst_level got %h want 0", r); end
  endtask

  task automatic test_tx_back_to_back;
    logic [31:0] r;
    logic [19:0] got;
    wr(A_DIV, 32'd3);
    rd(A_DIV, r);
    n_cmp++; if (r !== 32'd3) begin n_bad++; $display("FAIL div_rb got %0d want 3", r); end
    wr(A_DATA, 32'h55);
    wr(A_DATA, 32'hA3);
    // now 1.5 clocks into the first start bit; step one 4-clock bit at a time
    for (int i = 0; i < 20; i++) begin
      got[i] = uart_txd;
      if (i < 19) repeat (4) @(negedge clk);
    end
    n_cmp++; if (got !== {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0}) begin n_bad++;
      $display("FAIL tx_frames got %b want %b", got, {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0}); end
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h10) begin n_bad++; $display("FAIL tx_busy_stat got %h want 10", r); end
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h30) begin n_bad++; $display("FAIL tx_idle_stat got %h want 30", r); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] r;
    wr(A_DIV, 32'd15);
    for (int b = 0; b < 17; b++) rx_send(8'(b), 1'b1, 16);
    rd(A_LVL, r);
    n_cmp++; if (r !== 32'h10) begin n_bad++; $display("FAIL ovr_level got %h want 10", r); end
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h37) begin n_bad++; $display("FAIL ovr_stat got %h want 37", r); end
    for (int i = 0; i < 16; i++) begin
      rd(A_DATA, r);
      n_cmp++; if (r !== 32'(i)) begin n_bad++; $display("FAIL rx_pop%0d got %h want %h", i, r, i); end
    end
    rd(A_DATA, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rx_empty_read got %h want 0", r); end
    rd(A_LVL, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rx_drained_level got %h want 0", r); end
    wr(A_STAT, 32'h04);
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h30) begin n_bad++; $display("FAIL ovr_w1c got %h want 30", r); end
  endtask

  task automatic test_errors_intr;
    logic [31:0] r;
    wr(A_CTRL, 32'h4);
    rx_send(8'h81, 1'b0, 16);
    n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL ferr_intr got %b want 1", intr); end
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'hF0) begin n_bad++; $display("FAIL ferr_stat got %h want f0", r); end
    rd(A_LVL, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL ferr_level got %h want 0", r); end
    wr(A_STAT, 32'h40);
    @(negedge clk);
    n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL ferr_clr_intr got %b want 0", intr); end
    wr(A_CTRL, 32'h2);
    @(negedge clk);
    n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL tx_ie_intr got %b want 1", intr); end
    wr(A_CTRL, 32'h0);
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h30) begin n_bad++; $display("FAIL err_clean_stat got %h want 30", r); end
  endtask

  task automatic test_glitch;
    logic [31:0] r;
    @(negedge clk); uart_rxd = 1'b0;
    repeat (4) @(negedge clk); uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    rd(A_LVL, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL glitch_level got %h want 0", r); end
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h30) begin n_bad++; $display("FAIL glitch_stat got %h want 30", r); end
  endtask

  task automatic test_concurrent;
    logic [31:0] r, ra, rb;
    rx_send(8'h5A, 1'b1, 16);
    @(negedge clk);
    // DATA read is timed to land on the same edge as the next byte's stop-bit push
    fork
      rx_send(8'hC3, 1'b1, 16);
      begin
        wr(A_DATA, 32'h11); wr(A_DATA, 32'h22);
        repeat (149) @(negedge clk);
        rd(A_DATA, ra);
        rd(A_LVL, rb);
      end
    join
    n_cmp++; if (ra !== 32'h5A) begin n_bad++; $display("FAIL pushpop_full got %h want 5a", ra); end
    n_cmp++; if (rb !== 32'h0101) begin n_bad++; $display("FAIL pushpop_level got %h want 0101", rb); end
    rd(A_DATA, r);
    n_cmp++; if (r !== 32'hC3) begin n_bad++; $display("FAIL pushed_byte got %h want c3", r); end
    @(negedge clk);
    fork
      rx_send(8'h3C, 1'b1, 16);
      begin
        repeat (153) @(negedge clk);
        rd(A_DATA, ra);
        rd(A_LVL, rb);
      end
    join
    n_cmp++; if (ra !== 32'h3C) begin n_bad++; $display("FAIL pushpop_empty got %h want 3c", ra); end
    n_cmp++; if (rb[7:0] !== 8'h00) begin n_bad++; $display("FAIL pushpop_empty_lvl got %h want 00", rb[7:0]); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] r;
    wr(A_CTRL, 32'h7);
    wr(A_DATA, 32'hAA); wr(A_DATA, 32'h0F);
    repeat (30) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    n_cmp++; if (uart_txd !== 1'b1) begin n_bad++; $display("FAIL mid_rst_txd got %b want 1", uart_txd); end
    @(negedge clk); reset = 1'b0;
    rd(A_DIV, r);
    n_cmp++; if (r !== 32'd867) begin n_bad++; $display("FAIL mid_rst_div got %0d want 867", r); end
    rd(A_STAT, r);
    n_cmp++; if (r !== 32'h30) begin n_bad++; $display("FAIL mid_rst_stat got %h want 30", r); end
    rd(A_LVL, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL mid_rst_level got %h want 0", r); end
    n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL mid_rst_intr got %b want 0", intr); end
  endtask

  initial begin
    test_reset;
    test_tx_back_to_back;
    test_rx_overrun;
    test_errors_intr;
    test_glitch;
    test_concurrent;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 50000 clocks");
    $fatal(1, "watchdog");
  end
endmodule
